setres_debouncer: RTL and testbench

Front-end conditioning stage that feeds the synchronous set/reset D flip-flop from asynchronous, bouncy board-level inputs (push-buttons/switches). It synchronises three raw inputs (reset request, set request, data), debounces each independently, and drives the flop's `r`, `s` and `d` inputs with clean, clock-aligned signals. It also enforces reset-over-set priority so the downstream flop never sees a contradictory command.

---
 rtl/setres_debouncer_pkg.sv | 17 +
 rtl/setres_debouncer_debounce_chan.sv | 58 +++++
 rtl/setres_debouncer.sv | 73 +++++++
 tb/tb_setres_debouncer.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/setres_debouncer_pkg.sv
// Shared constants and helpers for the set/reset input conditioning front end.
// SETRES_PULSE_EN selects one-shot r/s commands instead of debounced levels.
package setres_pkg;

   localparam int SETRES_DEBOUNCE_DEFAULT = 16;

   localparam int CH_R   = 0;
   localparam int CH_S   = 1;
   localparam int CH_D   = 2;
   localparam int NUM_CH = 3;

   // The counter only has to reach DEBOUNCE_CYCLES-1, so n+1 states are enough.
   function automatic int cnt_w(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/setres_debouncer_debounce_chan.sv
// One conditioning channel: two-flop synchroniser, qualification counter and
// the accepted (stable) level, plus a one-cycle flag after stable rises.
module debounce_chan
   import setres_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = SETRES_DEBOUNCE_DEFAULT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic stable,
   output logic rise
);

   localparam int CW = cnt_w(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_q;
   logic          sync2_q;
   logic          stable_q;
   logic          stable_d;
   logic          prev_q;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Any return to equality before acceptance throws the partial count away.
   always_comb begin
      stable_d = stable_q;
      cnt_d    = '0;
      if (sync2_q != stable_q) begin
         if (cnt_q == CNT_LAST) begin
            stable_d = sync2_q;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         stable_q <= 1'b0;
         prev_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         sync1_q  <= raw;
         sync2_q  <= sync1_q;
         stable_q <= stable_d;
         prev_q   <= stable_q;
         cnt_q    <= cnt_d;
      end
   end

   assign stable = stable_q;
   assign rise   = stable_q & ~prev_q;

endmodule

// File: rtl/setres_debouncer.sv
// Conditions raw reset/set/data inputs for a set/reset flop, reset wins over set.
// Define SETRES_PULSE_EN for single-cycle r/s commands; otherwise r/s are levels.
module setres_debouncer
   import setres_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = SETRES_DEBOUNCE_DEFAULT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw_r,
   input  logic raw_s,
   input  logic raw_d,
   output logic r,
   output logic s,
   output logic d
);

   logic [NUM_CH-1:0] raw_w;
   logic [NUM_CH-1:0] stable_w;
   logic [NUM_CH-1:0] rise_w;
   logic              r_q;
   logic              s_q;
   logic              d_q;
   logic              unused_ok;

   always_comb begin
      raw_w       = '0;
      raw_w[CH_R] = raw_r;
      raw_w[CH_S] = raw_s;
      raw_w[CH_D] = raw_d;
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
      debounce_chan #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_chan (
         .clk   (clk),
         .rst_n (rst_n),
         .raw   (raw_w[g]),
         .stable(stable_w[g]),
         .rise  (rise_w[g])
      );
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_q <= 1'b0;
         s_q <= 1'b0;
         d_q <= 1'b0;
      end else begin
`ifdef SETRES_PULSE_EN
         // A set edge coinciding with, or landing under, a reset pulse is dropped.
         r_q <= rise_w[CH_R];
         s_q <= rise_w[CH_S] & ~rise_w[CH_R] & ~r_q;
`else
         r_q <= stable_w[CH_R];
         s_q <= stable_w[CH_S] & ~stable_w[CH_R];
`endif
         d_q <= stable_w[CH_D];
      end
   end

`ifdef SETRES_PULSE_EN
   assign unused_ok = rise_w[CH_D] ^ stable_w[CH_R] ^ stable_w[CH_S];
`else
   assign unused_ok = ^rise_w;
`endif

   assign r = r_q;
   assign s = s_q;
   assign d = d_q;

endmodule

// File: tb/tb_setres_debouncer.sv
// Directed bench for setres_debouncer: DEBOUNCE_CYCLES=4 main instance plus a
// DEBOUNCE_CYCLES=1 instance; level or pulse expectations follow SETRES_PULSE_EN.
module tb_setres_debouncer;

`ifdef SETRES_PULSE_EN
   localparam bit PULSE = 1'b1;
`else
   localparam bit PULSE = 1'b0;
`endif

   logic clk;
   logic rst_n;
   logic raw_r, raw_s, raw_d;
   logic r, s, d;
   logic raw_r1;
   logic r1, s1, d1;

   int checks   = 0;
   int failures = 0;

   setres_debouncer #(.DEBOUNCE_CYCLES(4)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .raw_r(raw_r),
      .raw_s(raw_s),
      .raw_d(raw_d),
      .r    (r),
      .s    (s),
      .d    (d)
   );

   setres_debouncer #(.DEBOUNCE_CYCLES(1)) dut_min (
      .clk  (clk),
      .rst_n(rst_n),
      .raw_r(raw_r1),
      .raw_s(1'b0),
      .raw_d(1'b0),
      .r    (r1),
      .s    (s1),
      .d    (d1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance n rising edges; inputs change and outputs are sampled 1 time unit after an edge.
   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n  = 1'b0;
      raw_r  = 1'b0;
      raw_s  = 1'b0;
      raw_d  = 1'b0;
      raw_r1 = 1'b0;

      // Reset state
      step(2);
      check("rst_r", r, 1'b0);
      check("rst_s", s, 1'b0);
      check("rst_d", d, 1'b0);
      check("rst_r1", r1, 1'b0);
      rst_n = 1'b1;
      step(2);
      check("idle_r", r, 1'b0);

      // Clean assertion of set: s appears after edge 6
      raw_s = 1'b1;
      step(6);
      check("set_e5", s, 1'b0);
      step(1);
      check("set_e6", s, 1'b1);
      check("set_e6_r", r, 1'b0);
      step(1);
      check("set_e7", s, PULSE ? 1'b0 : 1'b1);
      step(5);
      check("set_hold", s, PULSE ? 1'b0 : 1'b1);
      raw_s = 1'b0;
      step(6);
      check("set_rel_e5", s, PULSE ? 1'b0 : 1'b1);
      step(2);
      check("set_rel", s, 1'b0);

      // Bounce rejection on d: high 3, low 1, high 3, low
      raw_d = 1'b1;
      for (int i = 0; i < 3; i++) begin step(1); check("bnc_a", d, 1'b0); end
      raw_d = 1'b0;
      step(1); check("bnc_b", d, 1'b0);
      raw_d = 1'b1;
      for (int i = 0; i < 3; i++) begin step(1); check("bnc_c", d, 1'b0); end
      raw_d = 1'b0;
      for (int i = 0; i < 8; i++) begin step(1); check("bnc_d", d, 1'b0); end

      // d acceptance then release latency
      raw_d = 1'b1;
      step(7);
      check("d_high", d, 1'b1);
      step(3);
      raw_d = 1'b0;
      step(6);
      check("d_rel_e5", d, 1'b1);
      step(1);
      check("d_rel_e6", d, 1'b0);

      // Simultaneous reset and set requests
      raw_r = 1'b1;
      raw_s = 1'b1;
      step(6);
      check("sim_e5_r", r, 1'b0);
      check("sim_e5_s", s, 1'b0);
      step(1);
      check("sim_e6_r", r, 1'b1);
      check("sim_e6_s", s, 1'b0);
      step(1);
      check("sim_e7_r", r, PULSE ? 1'b0 : 1'b1);
      check("sim_e7_s", s, 1'b0);
      raw_r = 1'b0;
      step(7);
      check("sim_rel_r", r, 1'b0);
      check("sim_rel_s", s, PULSE ? 1'b0 : 1'b1);
      raw_s = 1'b0;
      step(8);
      check("sim_clr_s", s, 1'b0);

      // Reset mid-qualification: raw_r set before edge 0, rst_n low at edge 4
      raw_r = 1'b1;
      step(4);
      rst_n = 1'b0;
      step(1);
      check("midrst_r", r, 1'b0);
      check("midrst_s", s, 1'b0);
      check("midrst_d", d, 1'b0);
      rst_n = 1'b1;
      step(6);
      check("requal_e5", r, 1'b0);
      step(1);
      check("requal_e6", r, 1'b1);
      raw_r = 1'b0;
      step(8);
      check("requal_clr", r, 1'b0);

      // Minimum parameter: 2-cycle raw_r pulse on the DEBOUNCE_CYCLES=1 instance
      raw_r1 = 1'b1;
      step(2);
      check("min_e1", r1, 1'b0);
      raw_r1 = 1'b0;
      step(1);
      check("min_e2", r1, 1'b0);
      step(1);
      check("min_e3", r1, 1'b1);
      step(1);
      check("min_e4", r1, PULSE ? 1'b0 : 1'b1);
      step(1);
      check("min_e5", r1, 1'b0);
      check("min_s1", s1, 1'b0);
      check("min_d1", d1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
